branch_pred_checker: RTL
========================

# branch_pred_checker

Parametrised branch-prediction checker for the fetch/execute path. Each issued branch pushes its predicted direction into an in-order queue of outstanding predictions; each resolution from execute is compared against the oldest entry. A mismatch raises a one-cycle mispredict/flush pulse and discards all younger entries. Saturating hit/miss counters feed the performance statistics.

## Interface
Parameters:
- DEPTH, 4, max outstanding unresolved branches; power of two, 2..32
- CNT_W, 16, width of hit/miss statistic counters
- PTR_W, $clog2(DEPTH), derived; not overridden

Ports (clock and reset first):
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_br  input  1  branch issued this cycle; push request
- i_pred  input  1  predicted direction of the issued branch (1 = taken)
- i_res_valid  input  1  resolution of the oldest outstanding branch is valid
- i_res_taken  input  1  actual direction of the resolving branch
- i_clr_stats  input  1  synchronous clear of hit/miss counters
- o_res_valid  output  1  registered pulse: a comparison completed
- o_correct  output  1  result of the last comparison; holds between comparisons
- o_flush  output  1  registered pulse: mispredict, younger entries discarded
- o_full  output  1  count == DEPTH
- o_empty  output  1  count == 0
- o_count  output  PTR_W+1  outstanding entries
- o_overflow  output  1  sticky: push attempted while full
- o_underflow  output  1  sticky: resolution while empty
- o_hit_cnt  output  CNT_W  saturating count of correct predictions
- o_miss_cnt  output  CNT_W  saturating count of mispredictions

## Operation
- Storage: DEPTH x 1-bit circular buffer, read pointer rd, write pointer wr (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Push: i_br && (!full || resolve_ok) && !mispredict -> mem[wr] <= i_pred, wr+1. resolve_ok = correct resolution in the same cycle (head frees a slot).
- Resolve: i_res_valid && !empty -> compare mem[rd] with i_res_taken.
  - Match: rd+1, count-1 (+1 if push, net 0); o_res_valid=1, o_correct=1, hit_cnt+1.
  - Mismatch: rd, wr, count reset to 0 (flush all entries including head); same-cycle push dropped (wrong-path branch, not an overflow); o_res_valid=1, o_correct=0, o_flush=1, miss_cnt+1.
- i_res_valid while empty: no compare, no counter change, o_underflow <= 1.
- i_br while full and no correct resolution this cycle: push dropped, o_overflow <= 1.
- Sticky flags clear only on reset. Counters saturate at 2^CNT_W-1; i_clr_stats zeroes both and wins over same-cycle increment.
- Two-state control per comparison result: IDLE (no compare this cycle, o_res_valid=0, o_flush=0, o_correct holds) / CHECK (compare this cycle, pulses valid one cycle later). No multi-cycle states.

## Timing
- Reset (i_rst_n=0 at edge): count=0, rd=wr=0, o_res_valid=0, o_correct=1, o_flush=0, o_overflow=0, o_underflow=0, o_hit_cnt=0, o_miss_cnt=0; o_empty=1, o_full=0. Reset mid-operation discards all entries.
- Comparison latency: 1 cycle; resolution at edge N -> o_res_valid/o_correct/o_flush visible after edge N+1, high for exactly one cycle (unless another resolution follows).
- o_count, o_full, o_empty reflect registered count; update the cycle after push/resolve/flush.
- Back-to-back pushes and resolutions sustain one each per cycle.
- Pushed entry is resolvable no earlier than the cycle after its push (no bypass from i_br to compare).

## Test plan
- Reset then push 1,0,1 (DEPTH=4), resolve 1,0,1 -> three o_res_valid pulses with o_correct=1, o_hit_cnt=3, o_empty=1, o_flush never asserted.
- Push 1,1,0; resolve 0 -> o_correct=0, o_flush=1 one cycle, o_count=0 next cycle, o_miss_cnt=1; later i_res_valid -> o_underflow=1.
- Fill 4 entries, push 5th alone -> o_overflow=1, count stays 4; fill 4, push + correct resolve same cycle -> count stays 4, no overflow.
- Mispredict resolve with simultaneous i_br -> count=0, o_overflow stays 0.
- Push/resolve 10 entries continuously through DEPTH=4 -> pointer wrap, all o_correct match expected pattern.
- CNT_W=2: 5 correct resolutions -> o_hit_cnt saturates at 3; i_clr_stats -> 0; assert i_rst_n=0 with 2 pending -> all outputs at reset values.

Source files
------------

// File: rtl/branch_pred_checker.sv
// -----------------------------------------------------------------------------
// branch_pred_checker
//
// Tracks the predicted direction of every issued branch in an in-order queue
// and checks each resolution from execute against the oldest outstanding
// prediction. A wrong prediction raises a one-cycle flush pulse and drops every
// outstanding entry, since all of them sit on the wrong path. Saturating
// hit/miss counters collect prediction statistics.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      synchronous active-low reset
//   i_br         branch issued this cycle (push request)
//   i_pred       predicted direction of the issued branch (1 = taken)
//   i_res_valid  resolution of the oldest outstanding branch
//   i_res_taken  actual direction of the resolving branch
//   i_clr_stats  synchronous clear of the hit/miss counters
//   o_res_valid  one-cycle pulse, a comparison completed
//   o_correct    result of the most recent comparison, held between pulses
//   o_flush      one-cycle pulse, mispredict detected and queue emptied
//   o_full       queue holds DEPTH entries
//   o_empty      queue holds no entries
//   o_count      number of outstanding entries
//   o_overflow   sticky, push attempted while full
//   o_underflow  sticky, resolution arrived while empty
//   o_hit_cnt    saturating count of correct predictions
//   o_miss_cnt   saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_pred_checker #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_br,
   input  logic             i_pred,
   input  logic             i_res_valid,
   input  logic             i_res_taken,
   input  logic             i_clr_stats,
   output logic             o_res_valid,
   output logic             o_correct,
   output logic             o_flush,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_count,
   output logic             o_overflow,
   output logic             o_underflow,
   output logic [CNT_W-1:0] o_hit_cnt,
   output logic [CNT_W-1:0] o_miss_cnt
);

   typedef enum logic {IDLE, CHECK} state_t;

   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic             mem [DEPTH];
   logic [PTR_W-1:0] rd;
   logic [PTR_W-1:0] wr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic             last_match;
   logic             overflow;
   logic             underflow;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;
   state_t           state;
   state_t           state_next;

   logic empty;
   logic full;
   logic resolve;
   logic match;
   logic mispredict;
   logic push;

   // A correct resolution frees the head slot in the same cycle, so a push
   // into a full queue is still accepted then. A push alongside a mispredict
   // is a wrong-path branch and is dropped without counting as overflow.
   always_comb begin
      empty      = (count == '0);
      full       = (count == DEPTH_CNT);
      resolve    = i_res_valid && !empty;
      match      = resolve && (mem[rd] == i_res_taken);
      mispredict = resolve && !match;
      push       = i_br && (!full || match) && !mispredict;
   end

   // Occupancy update: a flush empties everything, otherwise push and
   // correct resolve each move the count by one and cancel when both occur.
   always_comb begin
      count_next = count;
      if (mispredict) begin
         count_next = '0;
      end else begin
         case ({push, match})
            2'b10:   count_next = count + (PTR_W+1)'(1);
            2'b01:   count_next = count - (PTR_W+1)'(1);
            default: count_next = count;
         endcase
      end
   end

   // Prediction storage; contents are only meaningful between rd and wr so
   // the array needs no reset.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr] <= i_pred;
      end
   end

   // Pointers, occupancy, last comparison result and sticky error flags.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rd         <= '0;
         wr         <= '0;
         count      <= '0;
         last_match <= 1'b1;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         count <= count_next;
         if (mispredict) begin
            rd <= '0;
            wr <= '0;
         end else begin
            if (match) rd <= rd + PTR_W'(1);
            if (push)  wr <= wr + PTR_W'(1);
         end
         if (resolve) last_match <= match;
         if (i_br && full && !resolve) overflow <= 1'b1;
         if (i_res_valid && empty) underflow <= 1'b1;
      end
   end

   // Statistics counters; a clear request takes priority over an increment
   // arriving in the same cycle, and both counters stop at all-ones.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (i_clr_stats) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (match && hit_cnt != CNT_MAX)       hit_cnt  <= hit_cnt + CNT_W'(1);
         if (mispredict && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

   // Result state register: CHECK marks the cycle after a comparison, which
   // is when the result pulses become visible.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Every cycle is decided afresh; there are no multi-cycle sequences.
   always_comb begin
      state_next = IDLE;
      if (resolve) state_next = CHECK;
   end

   // Result outputs derived from the registered state and comparison result.
   always_comb begin
      o_res_valid = (state == CHECK);
      o_flush     = (state == CHECK) && !last_match;
      o_correct   = last_match;
   end

   assign o_full      = full;
   assign o_empty     = empty;
   assign o_count     = count;
   assign o_overflow  = overflow;
   assign o_underflow = underflow;
   assign o_hit_cnt   = hit_cnt;
   assign o_miss_cnt  = miss_cnt;

endmodule
